alu_share_arb: RTL and testbench

- Shares one combinational ALU datapath between NREQ requesters (e.g. main pipeline EX stage and a multi-cycle helper unit).
- Each requester uses a valid/ready handshake. A round-robin arbiter grants one request per cycle.
- The granted operation runs through the ALU. Result, overflow flag and requester ID are captured in a one-entry output register with backpressure.

---
 rtl/alu_share_pkg.sv | 23 ++
 rtl/alu_share_alu.sv | 46 ++++
 rtl/rr_pick.sv | 31 +++
 rtl/alu_share_arb.sv | 172 +++++++++++++++++
 tb/tb_alu_share_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_pkg.sv
// Shared opcode encodings, requester-ID width and helpers for the alu_share_arb block.
package alu_share_pkg;

  localparam int ID_W = 2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MAX  = 4'b1010;

  function automatic logic is_ovf_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_share_alu.sv
// Combinational 32-bit ALU: result, signed add/sub overflow and illegal-opcode flag.
module alu_share_alu
  import alu_share_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o,
  output logic        ovf_o,
  output logic        illegal_o
);

  logic [32:0] sum;
  logic [32:0] diff;

  assign sum  = {a_i[31], a_i} + {b_i[31], b_i};
  assign diff = {a_i[31], a_i} - {b_i[31], b_i};

  always_comb begin
    y_o       = 32'd0;
    ovf_o     = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD:  y_o = sum[31:0];
      OP_SUB:  y_o = diff[31:0];
      OP_OR:   y_o = a_i | b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      // shifts move B by the amount in A[4:0]
      OP_SLL:  y_o = b_i << a_i[4:0];
      OP_SRL:  y_o = b_i >> a_i[4:0];
      OP_SRA:  y_o = $signed(b_i) >>> a_i[4:0];
      OP_SLT:  y_o = {31'd0, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: y_o = {31'd0, (a_i < b_i)};
      default: illegal_o = 1'b1;
    endcase
    if (is_ovf_op(op_i)) begin
      ovf_o = (op_i == OP_ADD) ? (sum[32] ^ sum[31]) : (diff[32] ^ diff[31]);
    end
    if (op_i > OP_MAX) begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ.
module rr_pick
  import alu_share_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (en && !found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          gnt[i] = 1'b1;
          idx    = ID_W'(i);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one ALU among NREQ requesters with a one-entry result register.
// Optional grant/stall statistics counters are enabled by defining ALU_SHARE_STATS_EN.
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [4*NREQ-1:0]     req_op,
  input  logic [32*NREQ-1:0]    req_a,
  input  logic [32*NREQ-1:0]    req_b,
  input  logic [TAG_W*NREQ-1:0] req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_ovf,
  output logic                  rsp_illegal,
  output logic [ID_W-1:0]       rsp_id,
  output logic [TAG_W-1:0]      rsp_tag
`ifdef ALU_SHARE_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [16*NREQ-1:0]    stat_grants,
  output logic [15:0]           stat_stall
`endif
);

  logic              can_issue;
  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              fire;
  logic [3:0]        op_sel;
  logic [31:0]       a_sel;
  logic [31:0]       b_sel;
  logic [TAG_W-1:0]  tag_sel;
  logic [31:0]       alu_y;
  logic              alu_ovf;
  logic              alu_illegal;

  logic              rsp_valid_q,   rsp_valid_d;
  logic [31:0]       rsp_data_q,    rsp_data_d;
  logic              rsp_ovf_q,     rsp_ovf_d;
  logic              rsp_illegal_q, rsp_illegal_d;
  logic [ID_W-1:0]   rsp_id_q,      rsp_id_d;
  logic [TAG_W-1:0]  rsp_tag_q,     rsp_tag_d;
  logic [ID_W-1:0]   rr_ptr_q,      rr_ptr_d;

  assign can_issue = !rsp_valid_q || rsp_ready;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (can_issue),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // Ready is forced low during reset so no requester sees a phantom accept.
  assign req_ready = gnt & {NREQ{reset_n}};
  assign fire      = |gnt;

  always_comb begin
    op_sel  = 4'd0;
    a_sel   = 32'd0;
    b_sel   = 32'd0;
    tag_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        op_sel  = req_op[4*i +: 4];
        a_sel   = req_a[32*i +: 32];
        b_sel   = req_b[32*i +: 32];
        tag_sel = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  alu_share_alu u_alu (
    .op_i      (op_sel),
    .a_i       (a_sel),
    .b_i       (b_sel),
    .y_o       (alu_y),
    .ovf_o     (alu_ovf),
    .illegal_o (alu_illegal)
  );

  always_comb begin
    rsp_data_d    = rsp_data_q;
    rsp_ovf_d     = rsp_ovf_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_id_d      = rsp_id_q;
    rsp_tag_d     = rsp_tag_q;
    rr_ptr_d      = rr_ptr_q;
    rsp_valid_d   = rsp_valid_q && !rsp_ready;
    if (fire) begin
      rsp_valid_d   = 1'b1;
      rsp_data_d    = alu_y;
      rsp_ovf_d     = alu_ovf;
      rsp_illegal_d = alu_illegal;
      rsp_id_d      = gnt_idx;
      rsp_tag_d     = tag_sel;
      rr_ptr_d      = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'd0;
      rsp_ovf_q     <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_id_q      <= '0;
      rsp_tag_q     <= '0;
      rr_ptr_q      <= '0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_ovf_q     <= rsp_ovf_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_id_q      <= rsp_id_d;
      rsp_tag_q     <= rsp_tag_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_ovf     = rsp_ovf_q;
  assign rsp_illegal = rsp_illegal_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_tag     = rsp_tag_q;

`ifdef ALU_SHARE_STATS_EN
  logic [NREQ-1:0][15:0] grants_q, grants_d;
  logic [15:0]           stall_q,  stall_d;

  always_comb begin
    grants_d = grants_q;
    stall_d  = stall_q;
    if (stat_clr) begin
      grants_d = '0;
      stall_d  = '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && grants_q[i] != 16'hFFFF) begin
          grants_d[i] = grants_q[i] + 16'd1;
        end
      end
      if (|req_valid && !can_issue && stall_q != 16'hFFFF) begin
        stall_d = stall_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grants_q <= '0;
      stall_q  <= '0;
    end else begin
      grants_q <= grants_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_grants = grants_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb (NREQ=2, TAG_W=4, statistics disabled).
module tb_alu_share_arb;

  localparam int NREQ  = 2;
  localparam int TAG_W = 4;

  logic                  clk;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [4*NREQ-1:0]     req_op;
  logic [32*NREQ-1:0]    req_a;
  logic [32*NREQ-1:0]    req_b;
  logic [TAG_W*NREQ-1:0] req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic                  rsp_ovf;
  logic                  rsp_illegal;
  logic [1:0]            rsp_id;
  logic [TAG_W-1:0]      rsp_tag;

  int n_cmp = 0;
  int n_err = 0;

  // {valid, data, ovf, illegal, id, tag}
  logic [40:0] obs;
  assign obs = {rsp_valid, rsp_data, rsp_ovf, rsp_illegal, rsp_id, rsp_tag};

  alu_share_arb #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_ovf     (rsp_ovf),
    .rsp_illegal (rsp_illegal),
    .rsp_id      (rsp_id),
    .rsp_tag     (rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int i, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    req_valid[i]         = v;
    req_op[4*i +: 4]     = op;
    req_a[32*i +: 32]    = a;
    req_b[32*i +: 32]    = b;
    req_tag[4*i +: 4]    = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    rsp_ready = 1'b1;
    drive(0, 1'b1, 4'd0, 32'd1, 32'd1, 4'd1);
    drive(1, 1'b1, 4'd0, 32'd2, 32'd2, 4'd2);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ready got %b exp %b", req_ready, 2'b00);
    end
    n_cmp++;
    if (obs !== 41'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %h exp %h", obs, 41'd0);
    end
    step();
    reset_n   = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy [4];
    logic [1:0] exp_id  [4];
    logic [40:0] exp;
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_id  = '{2'd0, 2'd1, 2'd0, 2'd1};
    rsp_ready = 1'b1;
    drive(0, 1'b1, 4'd0, 32'd1,  32'd2,  4'hA);
    drive(1, 1'b1, 4'd0, 32'd10, 32'd20, 4'hB);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== exp_rdy[k]) begin
        n_err++;
        $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_rdy[k]);
      end
      if (k > 0) begin
        exp = (exp_id[k-1] == 2'd0) ? {1'b1, 32'd3, 1'b0, 1'b0, 2'd0, 4'hA}
                                    : {1'b1, 32'd30, 1'b0, 1'b0, 2'd1, 4'hB};
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL rr_rsp[%0d] got %h exp %h", k - 1, obs, exp);
        end
      end
      step();
    end
    req_valid = '0;
    @(negedge clk);
    exp = {1'b1, 32'd30, 1'b0, 1'b0, 2'd1, 4'hB};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL rr_rsp[3] got %h exp %h", obs, exp);
    end
    step();
  endtask

  task automatic test_single_add();
    logic [40:0] exp;
    idle();
    drive(0, 1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1, 4'd3);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL add_ready got %b exp %b", req_ready, 2'b01);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    exp = {1'b1, 32'h8000_0000, 1'b1, 1'b0, 2'd0, 4'd3};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL add_rsp got %h exp %h", obs, exp);
    end
    step();
    @(negedge clk);
    exp = {1'b0, 32'h8000_0000, 1'b1, 1'b0, 2'd0, 4'd3};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL drain_hold got %h exp %h", obs, exp);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [40:0] exp;
    idle();
    rsp_ready = 1'b0;
    drive(0, 1'b1, 4'd2, 32'h0000_00F0, 32'h0000_000F, 4'd5);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL bp_first_ready got %b exp %b", req_ready, 2'b01);
    end
    step();
    drive(0, 1'b1, 4'd4, 32'h0000_00FF, 32'h0000_000F, 4'd6);
    drive(1, 1'b1, 4'd3, 32'h0000_00FF, 32'h0000_003C, 4'd7);
    exp = {1'b1, 32'h0000_00FF, 1'b0, 1'b0, 2'd0, 4'd5};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 2'b00) begin
        n_err++;
        $display("FAIL bp_ready[%0d] got %b exp %b", k, req_ready, 2'b00);
      end
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got %h exp %h", k, obs, exp);
      end
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req_ready} !== 3'b110) begin
      n_err++;
      $display("FAIL bp_release got %b exp %b", {rsp_valid, req_ready}, 3'b110);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    exp = {1'b1, 32'h0000_003C, 1'b0, 1'b0, 2'd1, 4'd7};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL bp_next_rsp got %h exp %h", obs, exp);
    end
    step();
  endtask

  task automatic test_sra_slt();
    logic [3:0]  ops  [4];
    logic [31:0] as   [4];
    logic [31:0] bs   [4];
    logic [31:0] ys   [4];
    logic        ovfs [4];
    logic [40:0] exp;
    ops  = '{4'd8, 4'd9, 4'd10, 4'd1};
    as   = '{32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    bs   = '{32'hF000_0000, 32'd0, 32'd0, 32'd1};
    ys   = '{32'hFF00_0000, 32'd1, 32'd0, 32'h7FFF_FFFF};
    ovfs = '{1'b0, 1'b0, 1'b0, 1'b1};
    idle();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, ops[k], as[k], bs[k], 4'(k + 1));
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 2'b01) begin
        n_err++;
        $display("FAIL ops_ready[%0d] got %b exp %b", k, req_ready, 2'b01);
      end
      if (k > 0) begin
        exp = {1'b1, ys[k-1], ovfs[k-1], 1'b0, 2'd0, 4'(k)};
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL ops_rsp[%0d] got %h exp %h", k - 1, obs, exp);
        end
      end
      step();
    end
    req_valid = '0;
    @(negedge clk);
    exp = {1'b1, ys[3], ovfs[3], 1'b0, 2'd0, 4'd4};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL ops_rsp[3] got %h exp %h", obs, exp);
    end
    step();
  endtask

  task automatic test_illegal();
    logic [40:0] exp;
    idle();
    drive(1, 1'b1, 4'hF, 32'd5, 32'd5, 4'd9);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_err++;
      $display("FAIL ill_ready got %b exp %b", req_ready, 2'b10);
    end
    step();
    drive(0, 1'b1, 4'd0, 32'd2, 32'd3, 4'd1);
    drive(1, 1'b1, 4'd0, 32'd7, 32'd7, 4'd2);
    @(negedge clk);
    exp = {1'b1, 32'd0, 1'b0, 1'b1, 2'd1, 4'd9};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL ill_rsp got %h exp %h", obs, exp);
    end
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL ill_ptr_adv got %b exp %b", req_ready, 2'b01);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    exp = {1'b1, 32'd5, 1'b0, 1'b0, 2'd0, 4'd1};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL ill_after got %h exp %h", obs, exp);
    end
    step();
  endtask

  task automatic test_reset_midop();
    logic [40:0] exp;
    idle();
    rsp_ready = 1'b0;
    drive(0, 1'b1, 4'd0, 32'd1, 32'd1, 4'd4);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL rst_pre_ready got %b exp %b", req_ready, 2'b01);
    end
    step();
    req_valid = '0;
    #2;
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pending got %b exp %b", rsp_valid, 1'b1);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_data} !== 33'd0) begin
      n_err++;
      $display("FAIL rst_async got %h exp %h", {rsp_valid, rsp_data}, 33'd0);
    end
    drive(0, 1'b1, 4'd0, 32'd2, 32'd2, 4'd8);
    drive(1, 1'b1, 4'd0, 32'd5, 32'd5, 4'hC);
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_held got %b exp %b", {rsp_valid, req_ready}, 3'b000);
    end
    step();
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL rst_first_grant got %b exp %b", req_ready, 2'b01);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    exp = {1'b1, 32'd4, 1'b0, 1'b0, 2'd0, 4'd8};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL rst_first_rsp got %h exp %h", obs, exp);
    end
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_single_add();
    test_backpressure();
    test_sra_slt();
    test_illegal();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
